fsm_vec_driver: RTL and testbench
=================================

// Module: fsm_vec_driver
// PURPOSE
//  Drives the (i,j) side and checks the (x,y) side of the 2-in/2-out FSM interface.
//  It is the other end of that interface: it produces i,j and consumes x,y.
//  A small vector table is loaded, then replayed one vector per clock. Each returned
//  {x,y} is compared against the expected value; mismatches are counted and reported.
//  Sits beside a 2-in/2-out Mealy FSM for on-chip self-test and bring-up.
// PARAMETERS
//  DEPTH  8  number of vector table entries (>=2); ADDR_W = $clog2(DEPTH) (localparam)
//  CNT_W  4  width of err_count; the count saturates at 2**CNT_W-1
// PORTS
//  clk            in   1         single clock, rising edge
//  rstn           in   1         asynchronous, active-low reset
//  load_en        in   1         write one table entry this cycle
//  load_addr      in   ADDR_W    entry index to write
//  load_ij        in   2         stimulus {i,j} for the entry
//  load_xy        in   2         expected {x,y} for the entry
//  len            in   ADDR_W+1  number of vectors to run (0..DEPTH); sampled with start
//  start          in   1         begin a run (accepted only in IDLE)
//  abort          in   1         stop a run; state goes to IDLE, no done pulse
//  x, y           in   1 each    FSM outputs (combinational Mealy response to i,j)
//  i, j           out  1 each    registered stimulus to the FSM
//  busy           out  1         high while in RUN
//  done           out  1         one-cycle pulse when a run completes
//  pass           out  1         run finished with err_count==0; valid from done until next start
//  err_count      out  CNT_W     mismatch count of the current or last run
//  first_err_idx  out  ADDR_W    index of the first mismatching vector; valid only if err_count!=0
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE; i=j=0, busy=0, done=0, pass=0, err_count=0,
//    first_err_idx=0, idx=0. Table contents are not reset (undefined until loaded).
//  Table writes: in IDLE or DONE, load_en writes {load_ij,load_xy} to mem[load_addr] at
//    the clock edge. load_en is ignored while busy. load_addr>=DEPTH is ignored.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  IDLE + start, len==0: go to DONE; clear err_count, first_err_idx and pass;
//    done pulses next cycle with pass=1.
//  IDLE + start, len>0: latch len; clear err_count, first_err_idx and pass; idx<=0;
//    {i,j}<=mem[0].ij; go to RUN. i,j lead by one edge.
//  RUN, each edge: sample {x,y} and compare with mem[idx].xy.
//    - Mismatch: err_count++ (saturating). If err_count was 0, first_err_idx<=idx.
//    - If idx==len-1: {i,j}<=00 and go to DONE.
//    - Otherwise: idx++ and {i,j}<=mem[idx+1].ij.
//  Run timing: len vectors take exactly len cycles in RUN. done rises on the edge after
//    the last compare. Latency from start to done is len+1 edges.
//  DONE: done=1 and pass=(err_count==0) for one cycle, then return to IDLE.
//    pass holds its value through IDLE.
//  Outside RUN, i and j are driven to 0.
//  start while busy: ignored. start and abort in the same cycle: abort wins.
//  abort in RUN: next edge gives IDLE with {i,j}=00 and no done pulse.
//    err_count and first_err_idx keep their partial values; pass stays 0.
//  len>DEPTH at start: clamp the run length to DEPTH.
//  rstn asserted mid-run: immediate return to reset values; the run is not resumed.
// TESTING
//  1 Reset: rstn=0 mid-RUN -> i,j,busy,done,err_count go to 0 asynchronously,
//    before the next clk edge.
//  2 Loopback model (x=i,y=j): load 4 entries ij=11,10,01,00 with xy equal to ij; len=4;
//    start -> busy for 4 cycles, i,j sequence 11,10,01,00, done pulse, pass=1, err_count=0.
//  3 Same loopback, expected xy of entry 2 set to 11 -> err_count=1, first_err_idx=2, pass=0.
//  4 Inverting model (x=~i,y=~j), len=8 -> err_count=8 (CNT_W=4, no saturation),
//    first_err_idx=0. Repeat with CNT_W=2 -> err_count holds at 3.
//  5 len=0 start -> done one cycle after start, pass=1, busy never high, i=j=0.
//  6 abort on run cycle 2 of len=6 -> IDLE next edge, no done pulse, i=j=0.
//    A start on the same cycle as abort is ignored. load_en during RUN leaves the table
//    unchanged; verify by rerunning.

Source files
------------

// File: rtl/fsm_vec_driver.sv
// Vector replay driver/checker for a 2-in/2-out Mealy FSM: drives {i,j} from a small
// table, one vector per clock, and counts mismatches of the returned {x,y}.
module fsm_vec_driver #(
   parameter int  DEPTH  = 8,
   parameter int  CNT_W  = 4,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [1:0]        load_ij,
   input  logic [1:0]        load_xy,
   input  logic [ADDR_W:0]   len,
   input  logic              start,
   input  logic              abort,
   input  logic              x,
   input  logic              y,
   output logic              i,
   output logic              j,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_idx
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   typedef struct packed {
      logic [1:0] ij;
      logic [1:0] xy;
   } vec_t;

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

   vec_t              mem_q [DEPTH];
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [1:0]        ij_q, ij_d;
   logic [CNT_W-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] first_q, first_d;
   logic              pass_q, pass_d;

   logic [ADDR_W:0]   len_clamp;
   logic              mismatch;
   logic              last_vec;
   vec_t              cur_vec;
   vec_t              nxt_vec;

   // NOTE: the vector table has no reset; it is only meaningful once loaded, and
   // leaving it out of the reset tree lets it map onto plain RAM/register-file cells.
   always_ff @(posedge clk) begin
      if (load_en && state_q != RUN && {1'b0, load_addr} < DEPTH_W)
         mem_q[load_addr] <= '{ij: load_ij, xy: load_xy};
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees
   // the pre-edge value of every other register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         ij_q    <= 2'b00;
         err_q   <= '0;
         first_q <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         ij_q    <= ij_d;
         err_q   <= err_d;
         first_q <= first_d;
         pass_q  <= pass_d;
      end
   end

   assign len_clamp = (len > DEPTH_W) ? DEPTH_W : len;
   assign cur_vec   = mem_q[idx_q];
   assign nxt_vec   = mem_q[idx_q + 1'b1];
   assign mismatch  = ({x, y} != cur_vec.xy);
   assign last_vec  = ({1'b0, idx_q} == len_q - 1'b1);

   // NOTE: every _d gets a default before the case, so no path leaves a
   // combinational output unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      ij_d    = 2'b00;
      err_d   = err_q;
      first_d = first_q;
      pass_d  = pass_q;
      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               err_d   = '0;
               first_d = '0;
               pass_d  = 1'b0;
               if (len_clamp == '0) begin
                  state_d = DONE;
                  pass_d  = 1'b1;
               end else begin
                  state_d = RUN;
                  len_d   = len_clamp;
                  idx_d   = '0;
                  ij_d    = mem_q[0].ij;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               if (mismatch) begin
                  if (err_q != '1) err_d = err_q + 1'b1;
                  if (err_q == '0) first_d = idx_q;
               end
               if (last_vec) begin
                  state_d = DONE;
                  pass_d  = (err_q == '0) && !mismatch;
               end else begin
                  idx_d = idx_q + 1'b1;
                  ij_d  = nxt_vec.ij;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy          = (state_q == RUN);
      done          = (state_q == DONE);
      i             = ij_q[1];
      j             = ij_q[0];
      pass          = pass_q;
      err_count     = err_q;
      first_err_idx = first_q;
   end

endmodule

// File: tb/tb_fsm_vec_driver.sv
// Bench for fsm_vec_driver: loopback/inverting FSM models, directed runs, and a
// scoreboard of expected run results checked whenever done is presented.
module tb_fsm_vec_driver;

   typedef struct packed {
      logic       pass;
      logic [3:0] err;
      logic [2:0] first;
      logic [1:0] err2;
   } exp_t;

   logic       clk, rstn;
   logic       load_en, start, abort;
   logic [2:0] load_addr;
   logic [1:0] load_ij, load_xy;
   logic [3:0] len;
   logic       invert;

   logic       x1, y1, i1, j1, busy, done, pass;
   logic [3:0] err_count;
   logic [2:0] first_err_idx;
   logic       x2, y2, i2, j2, busy2, done2, pass2;
   logic [1:0] err_count2;
   logic [2:0] first_err_idx2;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t mon_e;

   // Mealy FSM models: loopback (x=i,y=j) or inverting (x=~i,y=~j)
   assign x1 = invert ? ~i1 : i1;
   assign y1 = invert ? ~j1 : j1;
   assign x2 = invert ? ~i2 : i2;
   assign y2 = invert ? ~j2 : j2;

   fsm_vec_driver #(.DEPTH(8), .CNT_W(4)) dut (
      .clk(clk), .rstn(rstn), .load_en(load_en), .load_addr(load_addr),
      .load_ij(load_ij), .load_xy(load_xy), .len(len), .start(start), .abort(abort),
      .x(x1), .y(y1), .i(i1), .j(j1), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_idx(first_err_idx)
   );

   fsm_vec_driver #(.DEPTH(8), .CNT_W(2)) dut2 (
      .clk(clk), .rstn(rstn), .load_en(load_en), .load_addr(load_addr),
      .load_ij(load_ij), .load_xy(load_xy), .len(len), .start(start), .abort(abort),
      .x(x2), .y(y2), .i(i2), .j(j2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err_count2), .first_err_idx(first_err_idx2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expected result per done pulse
   always @(negedge clk) begin
      if (rstn && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending run (t=%0t)", $time);
         end else begin
            mon_e = sb.pop_front();
            check("done_pass", pass, mon_e.pass);
            check("done_err_count", err_count, mon_e.err);
            check("done_first_err_idx", first_err_idx, mon_e.first);
            check("done2_sync", done2, 1);
            check("done2_err_count", err_count2, mon_e.err2);
            check("done2_pass", pass2, mon_e.pass);
            check("done2_first_err_idx", first_err_idx2, mon_e.first);
            check("done_not_busy", {busy, busy2}, 0);
         end
      end
   end

   task automatic load_entry(input logic [2:0] a, input logic [1:0] ij, input logic [1:0] xy);
      @(negedge clk);
      load_en = 1'b1; load_addr = a; load_ij = ij; load_xy = xy;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   // Issues one run; seq holds expected {i,j} per RUN cycle, first vector in the MSBs
   task automatic run(input string name, input logic [3:0] l, input int exp_cycles,
                      input logic [15:0] seq, input bit exp_done, input exp_t e,
                      input int abort_at, input int load_at);
      int nbusy = 0;
      int lat = 0;
      if (exp_done) sb.push_back(e);
      @(negedge clk);
      start = 1'b1; len = l;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0; abort = 1'b0; load_en = 1'b0;
         if (busy) begin
            if (nbusy < 8) check({name, "_ij"}, {i1, j1}, seq[15 - 2*nbusy -: 2]);
            nbusy++;
         end
         if (done) begin
            lat = c;
            break;
         end
         if (c == abort_at) begin
            abort = 1'b1; start = 1'b1;
         end
         if (c == load_at) begin
            load_en = 1'b1; load_addr = 3'd0; load_ij = 2'b11; load_xy = 2'b00;
         end
         if (!exp_done && c >= abort_at + 5) break;
      end
      check({name, "_busy_cycles"}, nbusy, exp_cycles);
      if (exp_done) begin
         check({name, "_latency"}, lat, exp_cycles + 1);
         @(negedge clk);
         check({name, "_done_one_cycle"}, done, 0);
         check({name, "_pass_hold"}, pass, e.pass);
         check({name, "_ij_idle"}, {i1, j1}, 0);
      end else begin
         check({name, "_no_done"}, lat, 0);
         check({name, "_idle_busy"}, busy, 0);
         check({name, "_idle_ij"}, {i1, j1}, 0);
      end
   endtask

   initial begin
      rstn = 1'b0; load_en = 1'b0; load_addr = '0; load_ij = '0; load_xy = '0;
      len = '0; start = 1'b0; abort = 1'b0; invert = 1'b0;

      #2;
      check("rst_ij", {i1, j1}, 0);
      check("rst_busy_done_pass", {busy, done, pass}, 0);
      check("rst_err_count", err_count, 0);
      check("rst_first_err_idx", first_err_idx, 0);
      @(negedge clk);
      rstn = 1'b1;

      load_entry(3'd0, 2'b11, 2'b11);
      load_entry(3'd1, 2'b10, 2'b10);
      load_entry(3'd2, 2'b01, 2'b01);
      load_entry(3'd3, 2'b00, 2'b00);
      load_entry(3'd4, 2'b10, 2'b10);
      load_entry(3'd5, 2'b11, 2'b11);
      load_entry(3'd6, 2'b00, 2'b00);
      load_entry(3'd7, 2'b01, 2'b01);

      // Asynchronous reset in the middle of an erroring run
      invert = 1'b1;
      @(negedge clk);
      start = 1'b1; len = 4'd8;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("prerst_busy", busy, 1);
      check("prerst_err_count", err_count, 1);
      #1 rstn = 1'b0;
      #1;
      check("midrst_ij", {i1, j1}, 0);
      check("midrst_busy_done", {busy, done}, 0);
      check("midrst_err_count", err_count, 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("postrst_not_resumed", busy, 0);

      invert = 1'b0;
      run("loop4", 4'd4, 4, 16'hE400, 1'b1, '{pass:1'b1, err:4'd0, first:3'd0, err2:2'd0}, 0, 0);
      run("clamp12", 4'd12, 8, 16'hE4B1, 1'b1, '{pass:1'b1, err:4'd0, first:3'd0, err2:2'd0}, 0, 0);

      invert = 1'b1;
      run("invert8", 4'd8, 8, 16'hE4B1, 1'b1, '{pass:1'b0, err:4'd8, first:3'd0, err2:2'd3}, 0, 0);

      invert = 1'b0;
      load_entry(3'd2, 2'b01, 2'b11);
      run("bad_entry2", 4'd4, 4, 16'hE400, 1'b1, '{pass:1'b0, err:4'd1, first:3'd2, err2:2'd1}, 0, 0);

      run("len0", 4'd0, 0, 16'h0000, 1'b1, '{pass:1'b1, err:4'd0, first:3'd0, err2:2'd0}, 0, 0);

      load_entry(3'd2, 2'b01, 2'b01);
      run("abort", 4'd6, 2, 16'hE000, 1'b0, '0, 2, 0);
      check("abort_err_count", err_count, 0);
      check("abort_pass_low", pass, 0);

      // start together with abort in IDLE must not begin a run
      @(negedge clk);
      start = 1'b1; abort = 1'b1; len = 4'd4;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("start_abort_idle_busy", busy, 0);
      check("start_abort_idle_done", done, 0);

      run("load_in_run", 4'd4, 4, 16'hE400, 1'b1, '{pass:1'b1, err:4'd0, first:3'd0, err2:2'd0}, 0, 2);
      run("rerun", 4'd4, 4, 16'hE400, 1'b1, '{pass:1'b1, err:4'd0, first:3'd0, err2:2'd0}, 0, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
